// File: rtl/ucie_csr_mc_if.sv
// ucie_csr_mc_if: host register bus between a bus master and the ucie_csr_mc CSR block.
// Signals
//   write  : write strobe, one cycle per access
//   read   : read strobe, one cycle per access
//   addr   : byte address (word aligned)
//   wdata  : write data
//   rdata  : read data, valid while rvalid=1 (0 otherwise)
//   rvalid : read response strobe, one cycle after read
//   error  : access error, aligned with the response cycle
//   ready  : always 1 (single-cycle accept)
`timescale 1ns/1ps
interface ucie_csr_mc_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) ();
  logic              write;
  logic              read;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] rdata;
  logic              rvalid;
  logic              error;
  logic              ready;

  modport master (output write, read, addr, wdata, input rdata, rvalid, error, ready);
  modport slave  (input write, read, addr, wdata, output rdata, rvalid, error, ready);
endinterface

// File: rtl/ucie_csr_mc.sv
// ucie_csr_mc: multi-channel CSR block for the UCIe PHY test interface.
// One global bank (TOP_CFG, VERSION, IRQ_SUM, DEBUG) plus NUM_CH identical
// channel banks at CH_BASE + c*CH_STRIDE (CTRL, IG_DATA, EG_DATA, STA, IRQ_MASK, CMD).
// Ports
//   i_hclk, i_hreset    : clock, asynchronous active-high reset
//   bus                 : host register bus (slave side), 1-cycle read latency
//   o_intf_pipe_en      : TOP_CFG[12]
//   o_txrx_mode/o_pam4_en/o_pam4_cfg/o_ig_wdata : per-channel config, packed ch0 in LSBs
//   o_ig_wdata_upd/o_eg_rdata_upd/o_fifo_clr    : one-cycle command pulses
//   i_eg_rdata, i_debug : sampled every cycle into EG_DATA / DEBUG
//   i_ig_overflow/i_eg_overflow       : level events into sticky STA[0]/STA[1]
//   i_ig_write_done/i_eg_read_done    : rising-edge events into STA[2]/STA[3]
//   o_irq               : registered OR of (STA & IRQ_MASK) over all channels
`timescale 1ns/1ps
module ucie_csr_mc #(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int NUM_CH    = 2,
  parameter int CH_BASE   = 'h100,
  parameter int CH_STRIDE = 'h40
) (
  input  logic                     i_hclk,
  input  logic                     i_hreset,
  ucie_csr_mc_if.slave             bus,
  output logic                     o_intf_pipe_en,
  output logic [2*NUM_CH-1:0]      o_txrx_mode,
  output logic [NUM_CH-1:0]        o_pam4_en,
  output logic [8*NUM_CH-1:0]      o_pam4_cfg,
  output logic [DWIDTH*NUM_CH-1:0] o_ig_wdata,
  output logic [NUM_CH-1:0]        o_ig_wdata_upd,
  output logic [NUM_CH-1:0]        o_eg_rdata_upd,
  output logic [NUM_CH-1:0]        o_fifo_clr,
  input  logic [DWIDTH*NUM_CH-1:0] i_eg_rdata,
  input  logic [NUM_CH-1:0]        i_ig_overflow,
  input  logic [NUM_CH-1:0]        i_eg_overflow,
  input  logic [NUM_CH-1:0]        i_ig_write_done,
  input  logic [NUM_CH-1:0]        i_eg_read_done,
  input  logic [DWIDTH-1:0]        i_debug,
  output logic                     o_irq
);
  localparam int                SHIFT   = $clog2(CH_STRIDE);
  localparam logic [AWIDTH-1:0] BASE_A  = AWIDTH'(CH_BASE);
  localparam logic [DWIDTH-1:0] VERSION = DWIDTH'({16'(NUM_CH), 16'h0002});
  localparam logic [2:0] R_CTRL = 3'd0, R_IG = 3'd1, R_EG = 3'd2,
                         R_STA  = 3'd3, R_MASK = 3'd4, R_CMD = 3'd5;

  logic [DWIDTH-1:0]   top_cfg, debug_q, rdata_q;
  logic                rvalid_q, error_q, irq_q;
  logic [2*NUM_CH-1:0] txrx_q;
  logic [NUM_CH-1:0]   pam4_en_q;
  logic [8*NUM_CH-1:0] pam4_cfg_q;
  logic [DWIDTH-1:0]   ig_q [NUM_CH];
  logic [DWIDTH-1:0]   eg_q [NUM_CH];
  logic [3:0]          sta_q [NUM_CH];
  logic [3:0]          mask_q [NUM_CH];
  logic [3:0]          sta_set [NUM_CH];
  logic [3:0]          sta_clr [NUM_CH];
  logic [NUM_CH-1:0]   ig_upd_q, eg_upd_q, clr_q, ig_done_q, eg_done_q, irq_sum;

  logic [AWIDTH-1:0] ch_rel, ch_idx, ch_off;
  logic              g_hit, c_hit, hit, ro;
  logic [2:0]        reg_sel;
  logic [NUM_CH-1:0] ch_sel, ch_wr;
  logic              acc_rd, acc_err, do_wr;
  logic [DWIDTH-1:0] rd_val;

  // Address decode: channel index and in-bank offset come from the distance to CH_BASE.
  always_comb begin
    ch_rel  = bus.addr - BASE_A;
    ch_idx  = ch_rel >> SHIFT;
    ch_off  = ch_rel & AWIDTH'(CH_STRIDE - 1);
    g_hit   = (bus.addr[1:0] == 2'b00) && (bus.addr < AWIDTH'(16));
    c_hit   = (bus.addr[1:0] == 2'b00) && (bus.addr >= BASE_A) &&
              (ch_idx < AWIDTH'(NUM_CH)) && (ch_off <= AWIDTH'('h14));
    reg_sel = g_hit ? {1'b0, bus.addr[3:2]} : ch_off[4:2];
    ch_sel  = '0;
    for (int c = 0; c < NUM_CH; c++) ch_sel[c] = c_hit && (ch_idx == AWIDTH'(c));
    hit     = g_hit | c_hit;
    ro      = g_hit ? (reg_sel != 3'd0) : (reg_sel == R_EG);
    // Simultaneous read+write performs neither access.
    acc_rd  = bus.read & ~bus.write;
    do_wr   = bus.write & ~bus.read & hit & ~ro;
    acc_err = (bus.read & bus.write) | ((bus.read | bus.write) & ~hit) |
              (bus.write & ~bus.read & hit & ro);
    ch_wr   = ch_sel & {NUM_CH{do_wr}};
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      irq_sum[c] = |(sta_q[c] & mask_q[c]);
      sta_set[c] = {i_eg_read_done[c] & ~eg_done_q[c], i_ig_write_done[c] & ~ig_done_q[c],
                    i_eg_overflow[c], i_ig_overflow[c]};
      sta_clr[c] = (ch_wr[c] && reg_sel == R_STA) ? bus.wdata[3:0] : 4'h0;
    end
  end

  // Read mux; STA is read before this cycle's set is applied.
  always_comb begin
    rd_val = '0;
    if (g_hit) begin
      case (reg_sel[1:0])
        2'd0:    rd_val = top_cfg;
        2'd1:    rd_val = VERSION;
        2'd2:    rd_val = DWIDTH'(irq_sum);
        default: rd_val = debug_q;
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel[c]) begin
        case (reg_sel)
          R_CTRL:  rd_val = DWIDTH'({pam4_cfg_q[c*8 +: 8], 3'b000, pam4_en_q[c], 2'b00,
                                     txrx_q[c*2 +: 2]});
          R_IG:    rd_val = ig_q[c];
          R_EG:    rd_val = eg_q[c];
          R_STA:   rd_val = DWIDTH'(sta_q[c]);
          R_MASK:  rd_val = DWIDTH'(mask_q[c]);
          default: rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      top_cfg  <= DWIDTH'(32'h0000_1000);
      debug_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      error_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      debug_q  <= i_debug;
      rvalid_q <= acc_rd;
      rdata_q  <= (acc_rd && hit) ? rd_val : '0;
      error_q  <= acc_err;
      irq_q    <= |irq_sum;
      if (do_wr && g_hit && reg_sel == 3'd0) top_cfg <= bus.wdata;
    end
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      txrx_q     <= '0;
      pam4_en_q  <= '0;
      pam4_cfg_q <= '0;
      ig_upd_q   <= '0;
      eg_upd_q   <= '0;
      clr_q      <= '0;
      ig_done_q  <= '0;
      eg_done_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ig_q[c]   <= '0;
        eg_q[c]   <= '0;
        sta_q[c]  <= '0;
        mask_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        eg_q[c]      <= i_eg_rdata[c*DWIDTH +: DWIDTH];
        ig_done_q[c] <= i_ig_write_done[c];
        eg_done_q[c] <= i_eg_read_done[c];
        // Set has priority over a W1C in the same cycle.
        sta_q[c]     <= (sta_q[c] & ~sta_clr[c]) | sta_set[c];
        ig_upd_q[c]  <= ch_wr[c] && reg_sel == R_CMD && bus.wdata[0];
        eg_upd_q[c]  <= ch_wr[c] && reg_sel == R_CMD && bus.wdata[1];
        clr_q[c]     <= ch_wr[c] && reg_sel == R_CMD && bus.wdata[2];
        if (ch_wr[c]) begin
          case (reg_sel)
            R_CTRL: begin
              txrx_q[c*2 +: 2]     <= bus.wdata[1:0];
              pam4_en_q[c]         <= bus.wdata[4];
              pam4_cfg_q[c*8 +: 8] <= bus.wdata[15:8];
            end
            R_IG:    ig_q[c]   <= bus.wdata;
            R_MASK:  mask_q[c] <= bus.wdata[3:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    o_ig_wdata = '0;
    for (int c = 0; c < NUM_CH; c++) o_ig_wdata[c*DWIDTH +: DWIDTH] = ig_q[c];
  end

  assign bus.rdata      = rdata_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.error      = error_q;
  assign bus.ready      = 1'b1;
  assign o_intf_pipe_en = top_cfg[12];
  assign o_txrx_mode    = txrx_q;
  assign o_pam4_en      = pam4_en_q;
  assign o_pam4_cfg     = pam4_cfg_q;
  assign o_ig_wdata_upd = ig_upd_q;
  assign o_eg_rdata_upd = eg_upd_q;
  assign o_fifo_clr     = clr_q;
  assign o_irq          = irq_q;
endmodule

// File: tb/tb_ucie_csr_mc.sv
`timescale 1ns/1ps
module tb_ucie_csr_mc;
  localparam int AW = 32, DW = 32, NCH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ucie_csr_mc_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  logic              pipe_en, irq;
  logic [2*NCH-1:0]  txrx;
  logic [NCH-1:0]    pam4_en, ig_upd, eg_upd, fifo_clr;
  logic [8*NCH-1:0]  pam4_cfg;
  logic [DW*NCH-1:0] ig_wdata, eg_rdata;
  logic [NCH-1:0]    ig_ovf, eg_ovf, ig_done, eg_done;
  logic [DW-1:0]     dbg;

  ucie_csr_mc #(.AWIDTH(AW), .DWIDTH(DW), .NUM_CH(NCH), .CH_BASE('h100), .CH_STRIDE('h40)) dut (
    .i_hclk(clk), .i_hreset(rst), .bus(bus),
    .o_intf_pipe_en(pipe_en), .o_txrx_mode(txrx), .o_pam4_en(pam4_en), .o_pam4_cfg(pam4_cfg),
    .o_ig_wdata(ig_wdata), .o_ig_wdata_upd(ig_upd), .o_eg_rdata_upd(eg_upd), .o_fifo_clr(fifo_clr),
    .i_eg_rdata(eg_rdata), .i_ig_overflow(ig_ovf), .i_eg_overflow(eg_ovf),
    .i_ig_write_done(ig_done), .i_eg_read_done(eg_done), .i_debug(dbg), .o_irq(irq));

  // Reference model of the register contents
  logic [31:0] m_top;
  logic [1:0]  m_mode [NCH];
  logic        m_pen  [NCH];
  logic [7:0]  m_cfg  [NCH];
  logic [31:0] m_ig   [NCH];
  logic [3:0]  m_sta  [NCH];
  logic [3:0]  m_mask [NCH];

  typedef struct { int due; logic [33:0] resp; } resp_t;      // {rvalid, error, rdata}
  typedef struct { int due; logic [3*NCH-1:0] p; } pulse_t;   // {ig_upd, eg_upd, fifo_clr}
  resp_t  sb [$];
  pulse_t pq [$];
  resp_t  mon_r;
  pulse_t mon_p;

  int cyc = 0;
  int n_checks = 0, n_pass = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_top = 32'h0000_1000;
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 2'b00; m_pen[c] = 1'b0; m_cfg[c] = 8'h00;
      m_ig[c] = 32'h0; m_sta[c] = 4'h0; m_mask[c] = 4'h0;
    end
  endfunction

  function automatic logic model_irq();
    logic r = 1'b0;
    for (int c = 0; c < NCH; c++) r |= |(m_sta[c] & m_mask[c]);
    return r;
  endfunction

  // kind: 0 unmapped, 1 global register idx, 2 channel ch register idx
  function automatic void decode(input logic [31:0] a, output int kind, output int ch, output int idx);
    logic [31:0] rel, off;
    kind = 0; ch = 0; idx = 0;
    if (a[1:0] != 2'b00) return;
    if (a < 32'h10) begin
      kind = 1; idx = int'(a / 4);
    end else if (a >= 32'h100) begin
      rel = a - 32'h100;
      off = rel % 32'h40;
      if (rel / 32'h40 < NCH && off <= 32'h14) begin
        kind = 2; ch = int'(rel / 32'h40); idx = int'(off / 4);
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input int kind, input int ch, input int idx);
    logic [31:0] v = 32'h0;
    if (kind == 1) begin
      case (idx)
        0: v = m_top;
        1: v = (32'(NCH) << 16) | 32'h2;
        2: for (int c = 0; c < NCH; c++) v[c] = |(m_sta[c] & m_mask[c]);
        default: v = dbg;
      endcase
    end else if (kind == 2) begin
      case (idx)
        0: v = (32'(m_cfg[ch]) << 8) | (32'(m_pen[ch]) << 4) | 32'(m_mode[ch]);
        1: v = m_ig[ch];
        2: v = eg_rdata[ch*DW +: DW];
        3: v = 32'(m_sta[ch]);
        4: v = 32'(m_mask[ch]);
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int kind, ch, idx;
    bit ro, err;
    resp_t r;
    pulse_t p;
    @(posedge clk); #1;
    bus.read = rd; bus.write = wr; bus.addr = a; bus.wdata = d;
    decode(a, kind, ch, idx);
    ro  = (kind == 1 && idx != 0) || (kind == 2 && idx == 2);
    err = (rd && wr) || ((rd || wr) && kind == 0) || (wr && !rd && ro);
    r.due = cyc + 1;
    if (rd && !wr) begin
      r.resp = {1'b1, err, (err ? 32'h0 : model_read(kind, ch, idx))};
      sb.push_back(r);
    end else if (err) begin
      r.resp = {2'b01, 32'h0};
      sb.push_back(r);
    end
    if (wr && !rd && !err) begin
      if (kind == 1) m_top = d;
      else case (idx)
        0: begin m_mode[ch] = d[1:0]; m_pen[ch] = d[4]; m_cfg[ch] = d[15:8]; end
        1: m_ig[ch] = d;
        3: m_sta[ch] = (m_sta[ch] & ~d[3:0]) | {2'b00, eg_ovf[ch], ig_ovf[ch]};
        4: m_mask[ch] = d[3:0];
        5: begin
          p.due = cyc + 1; p.p = '0;
          p.p[2*NCH+ch] = d[0]; p.p[NCH+ch] = d[1]; p.p[ch] = d[2];
          if (p.p != '0) pq.push_back(p);
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      bus.read = 1'b0; bus.write = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NCH; c++) begin
      chk("txrx_mode", txrx[c*2 +: 2], m_mode[c]);
      chk("pam4_en", pam4_en[c], m_pen[c]);
      chk("pam4_cfg", pam4_cfg[c*8 +: 8], m_cfg[c]);
      chk("ig_wdata", ig_wdata[c*DW +: DW], m_ig[c]);
    end
    chk("intf_pipe_en", pipe_en, m_top[12]);
    chk("irq", irq, model_irq());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
    ig_ovf = '0; eg_ovf = '0; ig_done = '0; eg_done = '0;
    sb.delete(); pq.delete();
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // Monitor: compares every presented response/pulse against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_r = sb.pop_front();
        chk("resp", {bus.rvalid, bus.error, bus.rdata}, mon_r.resp);
      end else if (bus.rvalid || bus.error) begin
        chk("spurious_resp", {bus.rvalid, bus.error, bus.rdata}, 34'h0);
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
        mon_p = pq.pop_front();
        chk("pulse", {ig_upd, eg_upd, fifo_clr}, mon_p.p);
      end else if ({ig_upd, eg_upd, fifo_clr} != '0) begin
        chk("spurious_pulse", {ig_upd, eg_upd, fifo_clr}, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  logic [31:0] addr_tbl [22] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104, 32'h108,
                                 32'h10C, 32'h110, 32'h114, 32'h118, 32'h13C, 32'h140, 32'h144,
                                 32'h148, 32'h14C, 32'h150, 32'h154, 32'h158, 32'h180, 32'h102};

  initial begin
    rst = 1'b1;
    eg_rdata = {$urandom, $urandom};
    dbg = $urandom;
    do_reset();
    check_outputs();
    chk("ready", bus.ready, 1'b1);
    chk("pulses_rst", {ig_upd, eg_upd, fifo_clr}, 0);
    idle(2);

    // Global reads after reset
    access(1, 0, 32'h4, 0);
    access(1, 0, 32'h0, 0);
    access(1, 0, 32'hC, 0);
    access(1, 0, 32'h108, 0);
    access(1, 0, 32'h148, 0);
    idle(2);

    // ch1 CTRL
    access(0, 1, 32'h140, 32'h0000_A512);
    idle(2);
    chk("ctrl_txrx", txrx, 4'b1000);
    chk("ctrl_pam4_en", pam4_en, 2'b10);
    chk("ctrl_pam4_cfg", pam4_cfg, 16'hA500);
    check_outputs();
    access(1, 0, 32'h140, 0);

    // Command pulses and CMD read-back
    access(0, 1, 32'h114, 32'h5);
    access(1, 0, 32'h114, 0);
    idle(2);

    // Edge-triggered STA[2] on ch1 with mask -> irq, then W1C
    ig_done[1] = 1'b1;
    idle(2);
    ig_done[1] = 1'b0;
    m_sta[1] |= 4'h4;
    access(0, 1, 32'h150, 32'h4);
    access(1, 0, 32'h14C, 0);
    access(1, 0, 32'h8, 0);
    idle(2);
    chk("irq_set", irq, 1'b1);
    access(0, 1, 32'h14C, 32'h4);
    idle(2);
    chk("irq_clr", irq, 1'b0);
    access(1, 0, 32'h14C, 0);
    idle(1);

    // Level set wins over simultaneous W1C
    eg_ovf[0] = 1'b1;
    m_sta[0] |= 4'h2;
    idle(1);
    access(0, 1, 32'h10C, 32'h2);
    access(1, 0, 32'h10C, 0);
    idle(1);
    eg_ovf[0] = 1'b0;
    idle(1);
    access(0, 1, 32'h10C, 32'h2);
    access(1, 0, 32'h10C, 0);
    idle(1);

    // Error cases, state unchanged
    access(1, 0, 32'h180, 0);
    access(1, 0, 32'h118, 0);
    access(1, 1, 32'h0, 32'hFFFF_FFFF);
    access(0, 1, 32'h4, 32'h1234_5678);
    access(1, 0, 32'h0, 0);
    access(1, 0, 32'h4, 0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 11));
      a  = addr_tbl[$urandom_range(0, 21)];
      if (op <= 4)      access(1, 0, a, 0);
      else if (op <= 8) access(0, 1, a, $urandom);
      else if (op == 9) access(1, 1, a, $urandom);
      else              idle(1);
    end
    idle(2);
    check_outputs();

    // Reset in the middle of a read response
    access(1, 0, 32'h140, 0);
    @(posedge clk); #1;
    bus.read = 1'b0;
    rst = 1'b1;
    sb.delete(); pq.delete();
    #1;
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_irq", irq, 1'b0);
    do_reset();
    check_outputs();
    idle(2);
    access(1, 0, 32'h0, 0);
    access(1, 0, 32'h140, 0);
    access(1, 0, 32'h14C, 0);
    idle(3);
    chk("sb_drained", sb.size(), 0);
    chk("pq_drained", pq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
